// File: rtl/slave_req_tag_allocator.sv
// Tag allocator for the slave bridge request recorder: grants the lowest free slot, stages the
// recorder write and tracks occupancy. Optional SLAVE_TAG_STATS_EN adds hwm and err_cnt outputs.
module slave_req_tag_allocator #(
    parameter int TAG_WIDTH   = 5,
    parameter int ENTRY_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [ENTRY_WIDTH-1:0] alloc_entry,
    output logic [TAG_WIDTH-1:0]   alloc_tag,
    output logic                   req_wr_en,
    output logic [TAG_WIDTH-1:0]   req_wr_addr,
    output logic [ENTRY_WIDTH-1:0] req_wr_data,
    input  logic                   free_valid,
    input  logic [TAG_WIDTH-1:0]   free_tag,
    output logic                   free_err,
`ifdef SLAVE_TAG_STATS_EN
    output logic [TAG_WIDTH:0]     hwm,
    output logic [7:0]             err_cnt,
`endif
    output logic [TAG_WIDTH:0]     outstanding_cnt,
    output logic                   full,
    output logic                   empty
);

    localparam int NUM_TAGS = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0]   CNT_MAX = (TAG_WIDTH+1)'(NUM_TAGS);
    localparam logic [NUM_TAGS-1:0]  ONE_HOT0 = {{(NUM_TAGS-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, WRITE} wr_state_t;

    logic [NUM_TAGS-1:0]    busy_reg;
    logic [TAG_WIDTH:0]     cnt_reg, cnt_next;
    wr_state_t              state_reg;
    logic [TAG_WIDTH-1:0]   stage_tag_reg;
    logic [ENTRY_WIDTH-1:0] stage_entry_reg;
    logic                   free_err_reg;
    logic [TAG_WIDTH-1:0]   enc_tag;
    logic                   handshake;
    logic                   free_ok;
    logic [NUM_TAGS-1:0]    set_vec;
    logic [NUM_TAGS-1:0]    clr_vec;

    // Lowest free bit wins: scan downward so the last assignment is the lowest index.
    always_comb begin
        enc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_reg[i]) enc_tag = TAG_WIDTH'(i);
        end
    end

    assign full        = (cnt_reg == CNT_MAX);
    assign empty       = (cnt_reg == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = full ? '0 : enc_tag;
    assign handshake   = alloc_valid && alloc_ready;
    assign free_ok     = free_valid && busy_reg[free_tag];
    assign set_vec     = handshake ? (ONE_HOT0 << alloc_tag) : '0;
    assign clr_vec     = free_ok ? (ONE_HOT0 << free_tag) : '0;

    always_comb begin
        cnt_next = cnt_reg;
        if (handshake && !free_ok)      cnt_next = cnt_reg + 1'b1;
        else if (!handshake && free_ok) cnt_next = cnt_reg - 1'b1;
    end

    // A freed tag never collides with the granted one, so set/clear order per bit is moot.
    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_busy
            always_ff @(posedge clk or posedge arst) begin
                if (arst)             busy_reg[gi] <= 1'b0;
                else if (set_vec[gi]) busy_reg[gi] <= 1'b1;
                else if (clr_vec[gi]) busy_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_reg         <= '0;
            state_reg       <= IDLE;
            stage_tag_reg   <= '0;
            stage_entry_reg <= '0;
            free_err_reg    <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            free_err_reg <= free_valid && !busy_reg[free_tag];
            case (state_reg)
                IDLE:    state_reg <= handshake ? WRITE : IDLE;
                WRITE:   state_reg <= handshake ? WRITE : IDLE;
                default: state_reg <= IDLE;
            endcase
            if (handshake) begin
                stage_tag_reg   <= alloc_tag;
                stage_entry_reg <= alloc_entry;
            end
        end
    end

    assign req_wr_en       = (state_reg == WRITE);
    assign req_wr_addr     = stage_tag_reg;
    assign req_wr_data     = stage_entry_reg;
    assign free_err        = free_err_reg;
    assign outstanding_cnt = cnt_reg;

`ifdef SLAVE_TAG_STATS_EN
    logic [TAG_WIDTH:0] hwm_reg;
    logic [7:0]         err_cnt_reg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hwm_reg     <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (cnt_next > hwm_reg) hwm_reg <= cnt_next;
            if (free_err_reg && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign hwm     = hwm_reg;
    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: doc/slave_req_tag_allocator.md
Name: slave_req_tag_allocator

Overview:
- Upstream stage of the Slave Bridge Request Recorder. Allocates a free recorder slot (tag) to each outgoing non-posted AXI request.
- Drives the recorder's request-path write port with the request entry.
- Releases the slot when the P2A completion path retires it.
- Reports occupancy (outstanding count, full, empty) to the push FSM so the push FSM can stall.

Parameters:
- TAG_WIDTH, 5, tag/slot index width; equals recorder address width; NUM_TAGS = 2**TAG_WIDTH.
- ENTRY_WIDTH, 32, width of one recorder entry (AXI ID, length, size, attributes).

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- alloc_valid  in  1  push FSM requests a tag.
- alloc_ready  out  1  a tag can be granted this cycle.
- alloc_entry  in  ENTRY_WIDTH  entry to record for the granted tag.
- alloc_tag  out  TAG_WIDTH  tag granted on the handshake cycle.
- req_wr_en  out  1  recorder write enable (request path).
- req_wr_addr  out  TAG_WIDTH  recorder write address.
- req_wr_data  out  ENTRY_WIDTH  recorder write data.
- free_valid  in  1  P2A retires a tag.
- free_tag  in  TAG_WIDTH  tag being retired.
- free_err  out  1  one-cycle pulse: retire of a tag that is not busy.
- outstanding_cnt  out  TAG_WIDTH+1  number of busy tags.
- full  out  1  all tags busy.
- empty  out  1  no tag busy.

Behaviour:
- Reset values:
  - busy bitmap = 0, outstanding_cnt = 0, empty = 1, full = 0.
  - req_wr_en = 0, req_wr_addr = 0, req_wr_data = 0, free_err = 0.
  - alloc_ready = 1 once reset is released.
- Reset mid-operation: all state clears immediately; any write staged but not yet issued is dropped.
- alloc_ready = !full (combinational).
- alloc_tag = index of the lowest free bit of the registered bitmap (priority encoder, combinational). alloc_tag is 0 when full.
- Handshake = alloc_valid && alloc_ready. On the handshake edge:
  - busy[alloc_tag] <= 1.
  - Staging register <= {alloc_tag, alloc_entry}.
- Recorder write has 1-cycle latency: the cycle after the handshake, req_wr_en = 1, req_wr_addr = staged tag, req_wr_data = staged entry.
- Back-to-back handshakes produce back-to-back writes. req_wr_en is 0 in any cycle not preceded by a handshake.
- Free, with free_valid && busy[free_tag]: busy[free_tag] <= 0.
- Free, with free_valid && !busy[free_tag]:
  - Bitmap and count are unchanged.
  - free_err = 1 on the next cycle, for one cycle.
- Simultaneous handshake and valid free in one cycle:
  - Both take effect; outstanding_cnt is unchanged.
  - The freed tag is not grantable in the same cycle (the encoder uses the registered bitmap). It is grantable from the next cycle.
  - The freed tag cannot equal alloc_tag, because alloc_tag is free and the freed tag is busy.
- outstanding_cnt update: +1 on handshake only, −1 on valid free only, otherwise held. Range is 0..NUM_TAGS; no wrap.
- full = (outstanding_cnt == NUM_TAGS); empty = (outstanding_cnt == 0). Both are derived from registers.
- Full boundary: alloc_valid while full is not accepted; alloc_valid may stay high and is granted on the cycle after a free.
- Internal state machine (write stage): IDLE → WRITE on handshake. WRITE → WRITE on another handshake, else → IDLE. req_wr_en = (state == WRITE).

Optional Feature:
- Macro: SLAVE_TAG_STATS_EN.
- Defined:
  - Adds output hwm (TAG_WIDTH+1), the high-water mark of outstanding_cnt. hwm resets to 0 on arst and updates to max(hwm, next outstanding_cnt) each cycle.
  - Adds output err_cnt (8 bits), a saturating count of free_err pulses. err_cnt resets to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then three alloc handshakes with entries 0xA1, 0xB2, 0xC3 → alloc_tag 0, 1, 2. req_wr_en high for 3 cycles, each 1 cycle after its handshake, writing (0,0xA1), (1,0xB2), (2,0xC3). outstanding_cnt = 3.
- Fill all 32 tags → full = 1, alloc_ready = 0, alloc_tag = 0. Free tag 17 → next cycle alloc_ready = 1 and alloc_tag = 17; a held alloc_valid is granted tag 17.
- With tags 0..3 busy, alloc in the same cycle as freeing tag 1 → grant is tag 4, count stays 4. Next alloc → tag 1.
- Free tag 9 while it is not busy → free_err pulses 1 cycle, count unchanged. With SLAVE_TAG_STATS_EN, err_cnt = 1.
- Assert arst while a write is staged and 5 tags are busy → req_wr_en = 0, count = 0, empty = 1. The first alloc after reset gets tag 0.
- With SLAVE_TAG_STATS_EN: allocate 6, free 4, allocate 2 → hwm = 6 and outstanding_cnt = 4.
